// File: rtl/alu_op_sequencer.sv
// Issue/collect wrapper around the combinational 32-bit ALU: registers a request onto the
// ALU inputs, waits SETTLE_CYCLES, then captures and holds the result for downstream.
`timescale 1ns/1ps
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_A,
  input  logic [31:0]        in_B,
  input  logic [2:0]         in_op,
  output logic [31:0]        alu_A,
  output logic [31:0]        alu_B,
  output logic [2:0]         alu_op,
  input  logic [31:0]        alu_res,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_res,
  output logic               out_zero,
  output logic               out_overflow,
  output logic               ovf_sticky,
  input  logic               clr_sticky,
  output logic [COUNT_W-1:0] op_count,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state, state_next;
  logic [3:0] cnt;
  logic       accept, capture, consume;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE:    if (in_valid)     begin accept  = 1'b1; state_next = SETTLE; end
      SETTLE:  if (cnt == 4'd1)  begin capture = 1'b1; state_next = HOLD;   end
      HOLD:    if (out_ready)    begin consume = 1'b1; state_next = IDLE;   end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE) & ~rst;
  assign busy     = (state != IDLE);

  // Operands stay on the ALU after completion; only a new accept replaces them.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_A  <= '0;
      alu_B  <= '0;
      alu_op <= '0;
      cnt    <= '0;
    end else if (accept) begin
      alu_A  <= in_A;
      alu_B  <= in_B;
      alu_op <= in_op;
      cnt    <= SETTLE_LOAD;
    end else if (state == SETTLE) begin
      cnt    <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_res      <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_valid    <= 1'b0;
    end else if (capture) begin
      out_res      <= alu_res;
      out_zero     <= alu_zero;
      out_overflow <= alu_overflow;
      out_valid    <= 1'b1;
    end else if (consume) begin
      out_valid    <= 1'b0;
    end
  end

  // A captured overflow takes priority over a clear arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst)                          ovf_sticky <= 1'b0;
    else if (capture && alu_overflow) ovf_sticky <= 1'b1;
    else if (clr_sticky)              ovf_sticky <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)          op_count <= '0;
    else if (consume) op_count <= op_count + COUNT_W'(1);
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: one instance with SETTLE_CYCLES=1 on a combinational ALU and
// one with SETTLE_CYCLES=4 on an ALU whose result appears 3 cycles late.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid[2], out_ready[2], clr_sticky[2];
  logic [31:0] in_A, in_B;
  logic [2:0]  in_op;

  logic        in_ready[2], out_valid[2], out_zero[2], out_overflow[2], ovf_sticky[2], busy[2];
  logic        alu_zero[2], alu_overflow[2];
  logic [31:0] alu_A[2], alu_B[2], alu_res[2], out_res[2];
  logic [2:0]  alu_op[2];
  logic [15:0] op_count[2];

  int checks = 0;
  int errors = 0;
  int exp_count[2];
  bit exp_sticky[2];

  // Reference ALU: returns {res, zero, overflow}.
  function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b110: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b111: r = {31'b0, $signed(a) < $signed(b)};
      3'b100: r = ~(a | b);
      default: r = '0;
    endcase
    return {r, (r == 32'd0), v};
  endfunction

  always_comb {alu_res[0], alu_zero[0], alu_overflow[0]} = alu_ref(alu_A[0], alu_B[0], alu_op[0]);

  logic [33:0] pipe[3];
  always @(posedge clk) begin
    pipe[0] <= alu_ref(alu_A[1], alu_B[1], alu_op[1]);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign {alu_res[1], alu_zero[1], alu_overflow[1]} = pipe[2];

  alu_op_sequencer #(.SETTLE_CYCLES(1), .COUNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_A(in_A), .in_B(in_B), .in_op(in_op),
    .alu_A(alu_A[0]), .alu_B(alu_B[0]), .alu_op(alu_op[0]),
    .alu_res(alu_res[0]), .alu_zero(alu_zero[0]), .alu_overflow(alu_overflow[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_res(out_res[0]),
    .out_zero(out_zero[0]), .out_overflow(out_overflow[0]), .ovf_sticky(ovf_sticky[0]),
    .clr_sticky(clr_sticky[0]), .op_count(op_count[0]), .busy(busy[0])
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4), .COUNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_A(in_A), .in_B(in_B), .in_op(in_op),
    .alu_A(alu_A[1]), .alu_B(alu_B[1]), .alu_op(alu_op[1]),
    .alu_res(alu_res[1]), .alu_zero(alu_zero[1]), .alu_overflow(alu_overflow[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_res(out_res[1]),
    .out_zero(out_zero[1]), .out_overflow(out_overflow[1]), .ovf_sticky(ovf_sticky[1]),
    .clr_sticky(clr_sticky[1]), .op_count(op_count[1]), .busy(busy[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction on instance s, with stall cycles of backpressure and an optional
  // clr_sticky pulse on the capture edge. Called at a negedge with instance s idle.
  task automatic applyStimulus(input int s, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input int stall, input bit clr_cap);
    int          n = (s == 0) ? 1 : 4;
    logic [33:0] r = alu_ref(a, b, op);
    in_A = a; in_B = b; in_op = op; in_valid[s] = 1'b1;
    checkOutput("in_ready_idle", 32'(in_ready[s]), 32'd1);
    cycle();
    in_valid[s] = 1'b0;
    in_A = $urandom; in_B = $urandom; in_op = 3'($urandom);
    checkOutput("alu_A", alu_A[s], a);
    checkOutput("alu_B", alu_B[s], b);
    checkOutput("alu_op", 32'(alu_op[s]), 32'(op));
    checkOutput("busy_settle", 32'(busy[s]), 32'd1);
    for (int k = 1; k <= n; k++) begin
      if (k == n) clr_sticky[s] = clr_cap;
      cycle();
      clr_sticky[s] = 1'b0;
      checkOutput((k == n) ? "valid_rise" : "valid_early", 32'(out_valid[s]), 32'(k == n));
    end
    if (r[0]) exp_sticky[s] = 1'b1;
    else if (clr_cap) exp_sticky[s] = 1'b0;
    checkOutput("out_res", out_res[s], r[33:2]);
    checkOutput("out_zero", 32'(out_zero[s]), 32'(r[1]));
    checkOutput("out_overflow", 32'(out_overflow[s]), 32'(r[0]));
    checkOutput("ovf_sticky", 32'(ovf_sticky[s]), 32'(exp_sticky[s]));
    for (int k = 0; k < stall; k++) begin
      in_valid[s] = 1'b1;
      cycle();
      checkOutput("stall_valid", 32'(out_valid[s]), 32'd1);
      checkOutput("stall_res", out_res[s], r[33:2]);
      checkOutput("stall_in_ready", 32'(in_ready[s]), 32'd0);
      checkOutput("stall_alu_A", alu_A[s], a);
      checkOutput("stall_count", 32'(op_count[s]), 32'(exp_count[s] & 16'hFFFF));
    end
    out_ready[s] = 1'b1;
    cycle();
    out_ready[s] = 1'b0;
    in_valid[s]  = 1'b0;
    exp_count[s]++;
    checkOutput("valid_drop", 32'(out_valid[s]), 32'd0);
    checkOutput("op_count", 32'(op_count[s]), 32'(exp_count[s] & 16'hFFFF));
    checkOutput("busy_done", 32'(busy[s]), 32'd0);
    checkOutput("in_ready_done", 32'(in_ready[s]), 32'd1);
  endtask

  logic [2:0] ops_tbl[6] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100};

  initial begin
    bit          saw_valid;
    logic [31:0] ra, rb;
    rst = 1'b1;
    in_A = '0; in_B = '0; in_op = '0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b1; out_ready[s] = 1'b0; clr_sticky[s] = 1'b0;
      exp_count[s] = 0; exp_sticky[s] = 1'b0;
    end

    repeat (2) cycle();
    for (int s = 0; s < 2; s++) begin
      checkOutput("rst_in_ready", 32'(in_ready[s]), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid[s]), 32'd0);
      checkOutput("rst_out_res", out_res[s], 32'd0);
      checkOutput("rst_alu_A", alu_A[s], 32'd0);
      checkOutput("rst_count", 32'(op_count[s]), 32'd0);
      checkOutput("rst_sticky", 32'(ovf_sticky[s]), 32'd0);
      checkOutput("rst_busy", 32'(busy[s]), 32'd0);
    end
    rst = 1'b0;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    #1;
    checkOutput("post_rst_ready1", 32'(in_ready[0]), 32'd1);
    checkOutput("post_rst_ready4", 32'(in_ready[1]), 32'd1);
    @(negedge clk);

    // Reset in the middle of a settle window on the slow instance.
    in_A = 32'h1234_5678; in_B = 32'h1111_1111; in_op = 3'b010; in_valid[1] = 1'b1;
    cycle();
    in_valid[1] = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      saw_valid |= out_valid[1];
      cycle();
    end
    checkOutput("midrst_no_valid", 32'(saw_valid), 32'd0);
    checkOutput("midrst_count", 32'(op_count[1]), 32'd0);
    checkOutput("midrst_busy", 32'(busy[1]), 32'd0);

    out_ready[0] = 1'b1;
    cycle();
    out_ready[0] = 1'b0;
    checkOutput("idle_out_ready", 32'(op_count[0]), 32'd0);

    applyStimulus(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b010, 0, 1'b0);
    applyStimulus(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b110, 5, 1'b0);
    clr_sticky[0] = 1'b1;
    cycle();
    clr_sticky[0] = 1'b0;
    exp_sticky[0] = 1'b0;
    checkOutput("clr_after_sub", 32'(ovf_sticky[0]), 32'd0);

    applyStimulus(0, 32'h7FFFFFFF, 32'h00000001, 3'b010, 0, 1'b0);
    applyStimulus(0, 32'h00000005, 32'h00000003, 3'b010, 0, 1'b1);
    applyStimulus(0, 32'h80000000, 32'h80000000, 3'b010, 0, 1'b0);
    applyStimulus(0, 32'h80000000, 32'h00000001, 3'b110, 1, 1'b1);
    clr_sticky[0] = 1'b1;
    cycle();
    clr_sticky[0] = 1'b0;
    exp_sticky[0] = 1'b0;
    checkOutput("clr_alone", 32'(ovf_sticky[0]), 32'd0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      applyStimulus(0, ra, rb, ops_tbl[$urandom_range(0, 5)], $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
    end

    applyStimulus(1, 32'h0000_00FF, 32'h0000_0001, 3'b010, 0, 1'b0);
    applyStimulus(1, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b010, 2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      applyStimulus(1, ra, rb, ops_tbl[$urandom_range(0, 5)], $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
